wb_regfile: RTL

Writeback stage and architectural register file for the five-stage MIPS pipeline. It consumes the MEM/WB pipeline register outputs, selects the writeback value, and commits it to a 32 x 32-bit register file. It serves the two ID-stage read ports with same-cycle write-to-read bypass. It also exports the writeback value and qualifier for the EX-stage forwarding unit, plus a committed-write counter for debug.

---
 rtl/wb_regfile.sv | 68 ++++++
 1 files changed

// File: rtl/wb_regfile.sv
// Writeback stage and 2R/1W architectural register file with write-first bypass.
// Register 0 is hardwired to zero; a debug counter tracks committed writes.
module wb_regfile #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ctrl_regWrite_mem_wb,
    input  logic                  ctrl_memToReg_mem_wb,
    input  logic [DATA_WIDTH-1:0] read_data_from_mem_mem_wb,
    input  logic [DATA_WIDTH-1:0] alu_result_mem_wb,
    input  logic [ADDR_WIDTH-1:0] write_register_mem_wb,
    input  logic [ADDR_WIDTH-1:0] read_register_1,
    input  logic [ADDR_WIDTH-1:0] read_register_2,
    output logic [DATA_WIDTH-1:0] read_data_1,
    output logic [DATA_WIDTH-1:0] read_data_2,
    output logic [DATA_WIDTH-1:0] write_data_wb,
    output logic                  regWrite_wb,
    output logic [31:0]           wb_write_count
);

    localparam int unsigned NumRegs = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NumRegs];
    logic [31:0]           count_q;
    logic [31:0]           count_d;

    always_comb begin
        write_data_wb = ctrl_memToReg_mem_wb ? read_data_from_mem_mem_wb : alu_result_mem_wb;
        // Writes to $zero are dropped here so neither the array nor the counter sees them.
        regWrite_wb   = ctrl_regWrite_mem_wb && (write_register_mem_wb != '0);
        count_d       = count_q + 32'd1;
    end

    always_comb begin
        read_data_1 = regs_q[read_register_1];
        if (read_register_1 == '0) begin
            read_data_1 = '0;
        end else if (regWrite_wb && (write_register_mem_wb == read_register_1)) begin
            read_data_1 = write_data_wb;
        end
    end

    always_comb begin
        read_data_2 = regs_q[read_register_2];
        if (read_register_2 == '0) begin
            read_data_2 = '0;
        end else if (regWrite_wb && (write_register_mem_wb == read_register_2)) begin
            read_data_2 = write_data_wb;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
            count_q <= '0;
        end else if (regWrite_wb) begin
            regs_q[write_register_mem_wb] <= write_data_wb;
            count_q                       <= count_d;
        end
    end

    assign wb_write_count = count_q;

endmodule
